// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: segment vector type,
// blank pattern and the active-low hex glyphs, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    localparam seg7_t SEG_0 = 7'b1000000;
    localparam seg7_t SEG_1 = 7'b1111001;
    localparam seg7_t SEG_2 = 7'b0100100;
    localparam seg7_t SEG_3 = 7'b0110000;
    localparam seg7_t SEG_4 = 7'b0011001;
    localparam seg7_t SEG_5 = 7'b0010010;
    localparam seg7_t SEG_6 = 7'b0000010;
    localparam seg7_t SEG_7 = 7'b1111000;
    localparam seg7_t SEG_8 = 7'b0000000;
    localparam seg7_t SEG_9 = 7'b0010000;
    localparam seg7_t SEG_A = 7'b0001000;
    localparam seg7_t SEG_B = 7'b0000011;
    localparam seg7_t SEG_C = 7'b1000110;
    localparam seg7_t SEG_D = 7'b0100001;
    localparam seg7_t SEG_E = 7'b0000110;
    localparam seg7_t SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output seg7_t      seg_n
);

    // Full 16-entry glyph lookup
    always_comb begin
        seg_n = SEG_BLANK;
        case (nib)
            4'h0: seg_n = SEG_0;
            4'h1: seg_n = SEG_1;
            4'h2: seg_n = SEG_2;
            4'h3: seg_n = SEG_3;
            4'h4: seg_n = SEG_4;
            4'h5: seg_n = SEG_5;
            4'h6: seg_n = SEG_6;
            4'h7: seg_n = SEG_7;
            4'h8: seg_n = SEG_8;
            4'h9: seg_n = SEG_9;
            4'hA: seg_n = SEG_A;
            4'hB: seg_n = SEG_B;
            4'hC: seg_n = SEG_C;
            4'hD: seg_n = SEG_D;
            4'hE: seg_n = SEG_E;
            4'hF: seg_n = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with per-slot
// anode dead time, leading-zero blanking and frame-aligned double buffering.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp,
    input  logic                lzb,
    input  logic                load,
    output logic                busy,
    output logic                frame_tick,
    output logic [DIGITS-1:0]   an_n,
    output logic [6:0]          seg_n,
    output logic                dp_n
);

    localparam int VAL_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [VAL_W-1:0]  shadow_q, shadow_d;
    logic [VAL_W-1:0]  display_q, display_d;
    logic              busy_q, busy_d;
    logic              frame_tick_q, frame_tick_d;
    logic [DIGITS-1:0] an_n_q, an_n_d;
    seg7_t             seg_n_q, seg_n_d;
    logic              dp_n_q, dp_n_d;

    logic [3:0]        nib [DIGITS];
    logic [DIGITS-1:0] upper_zero;   // nibbles gi..DIGITS-1 of display are all zero
    logic [3:0]        cur_nib;
    seg7_t             dec_seg;
    logic              lzb_hide;
    logic              in_drive;
    logic              commit;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi]        = display_q[4*gi +: 4];
            assign upper_zero[gi] = (display_q[VAL_W-1:4*gi] == '0);
        end
    endgenerate

    assign cur_nib  = nib[idx_q];
    assign lzb_hide = lzb && (idx_q != '0) && upper_zero[idx_q];
    assign in_drive = (cnt_q >= CNT_BLANK) && !lzb_hide;
    assign commit   = enable && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

    seg7_hex_decode u_dec (
        .nib   (cur_nib),
        .seg_n (dec_seg)
    );

    // Slot counter and digit index; disabling parks both at zero
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!enable) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Shadow/display double buffer; a load coinciding with a commit (or with
    // the display going dark) bypasses straight into the display
    always_comb begin
        shadow_d     = shadow_q;
        display_d    = display_q;
        busy_d       = busy_q;
        frame_tick_d = commit;
        if (commit || !enable) begin
            if (load) begin
                shadow_d  = value;
                display_d = value;
                busy_d    = 1'b0;
            end else if (busy_q) begin
                display_d = shadow_q;
                busy_d    = 1'b0;
            end
        end else if (load) begin
            shadow_d = value;
            busy_d   = 1'b1;
        end
    end

    // Pin drive for the current phase, registered one cycle later
    always_comb begin
        an_n_d  = '1;
        seg_n_d = SEG_BLANK;
        dp_n_d  = 1'b1;
        if (enable && in_drive) begin
            an_n_d  = ~(DIGITS'(1) << idx_q);
            seg_n_d = dec_seg;
            dp_n_d  = ~dp[idx_q];
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            display_q    <= '0;
            busy_q       <= 1'b0;
            frame_tick_q <= 1'b0;
            an_n_q       <= '1;
            seg_n_q      <= SEG_BLANK;
            dp_n_q       <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            display_q    <= display_d;
            busy_q       <= busy_d;
            frame_tick_q <= frame_tick_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
        end
    end

    assign busy       = busy_q;
    assign frame_tick = frame_tick_q;
    assign an_n       = an_n_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
module tb_seg7_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G6 = 7'b0000010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GB = 7'b0000011;
    localparam logic [6:0] GC = 7'b1000110;
    localparam logic [6:0] GD = 7'b0100001;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        enable = 1'b0;
    logic        lzb    = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] value  = 16'h0000;
    logic [3:0]  dp     = 4'b0000;
    logic        busy;
    logic        frame_tick;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;

    int checks   = 0;
    int failures = 0;

    seg7_scan_ctrl #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .value      (value),
        .dp         (dp),
        .lzb        (lzb),
        .load       (load),
        .busy       (busy),
        .frame_tick (frame_tick),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ft(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        chk({tag, "_frame_tick_seen"}, 32'(seen), 32'd1);
    endtask

    // Walks one whole frame starting the cycle after a frame_tick (or restart)
    task automatic check_frame(input string tag, input logic [3:0][6:0] segs,
                               input logic [3:0] drv, input logic [3:0] dps);
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        for (int d = 0; d < 4; d++) begin
            for (int s = 0; s < SCAN_DIV; s++) begin
                tick();
                if (d == 0 && s == 0) chk({tag, "_ft_low"}, 32'(frame_tick), 32'd0);
                if (s < BLANK_CYC || !drv[d]) begin
                    ea = 4'hF;
                    es = 7'h7F;
                    ed = 1'b1;
                end else begin
                    ea = ~(4'b0001 << d);
                    es = segs[d];
                    ed = ~dps[d];
                end
                chk($sformatf("%s_an_d%0d_s%0d", tag, d, s), 32'(an_n), 32'(ea));
                chk($sformatf("%s_seg_d%0d_s%0d", tag, d, s), 32'(seg_n), 32'(es));
                chk($sformatf("%s_dp_d%0d_s%0d", tag, d, s), 32'(dp_n), 32'(ed));
            end
        end
        chk({tag, "_ft_end"}, 32'(frame_tick), 32'd1);
        $display("frame %s checked", tag);
    endtask

    initial begin
        // Reset state
        tick(); tick(); tick();
        chk("rst_an", 32'(an_n), 32'hF);
        chk("rst_seg", 32'(seg_n), 32'h7F);
        chk("rst_dp", 32'(dp_n), 32'd1);
        chk("rst_ft", 32'(frame_tick), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        $display("reset state checked");

        // 1: load 1234, commit at first frame boundary
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();
        load = 1'b1; value = 16'h1234;
        tick();
        load = 1'b0;
        chk("s1_busy_set", 32'(busy), 32'd1);
        wait_ft("s1", 40);
        chk("s1_busy_clr", 32'(busy), 32'd0);
        check_frame("s1_1234", {G1, G2, G3, G4}, 4'hF, 4'h0);

        // 2: two loads before commit, latest wins
        tick();
        load = 1'b1; value = 16'h1111;
        tick();
        load = 1'b0;
        tick();
        load = 1'b1; value = 16'h2222;
        tick();
        load = 1'b0;
        chk("s2_busy_set", 32'(busy), 32'd1);
        wait_ft("s2", 40);
        chk("s2_busy_clr", 32'(busy), 32'd0);
        check_frame("s2_2222", {G2, G2, G2, G2}, 4'hF, 4'h0);

        // 3: leading-zero blanking
        lzb  = 1'b1;
        load = 1'b1; value = 16'h0040;
        tick();
        load = 1'b0;
        wait_ft("s3a", 40);
        check_frame("s3_0040", {G0, G0, G4, G0}, 4'b0011, 4'h0);
        load = 1'b1; value = 16'h0000;
        tick();
        load = 1'b0;
        wait_ft("s3b", 40);
        check_frame("s3_0000", {G0, G0, G0, G0}, 4'b0001, 4'h0);
        lzb = 1'b0;

        // 4: load exactly on the commit cycle bypasses the shadow
        for (int i = 0; i < 4 * SCAN_DIV - 1; i++) tick();
        load = 1'b1; value = 16'hABCD;
        tick();
        load = 1'b0;
        chk("s4_ft", 32'(frame_tick), 32'd1);
        chk("s4_busy", 32'(busy), 32'd0);
        check_frame("s4_abcd", {GA, GB, GC, GD}, 4'hF, 4'h0);

        // 5: decimal point on digit 2 only
        dp = 4'b0100;
        check_frame("s5_dp", {GA, GB, GC, GD}, 4'hF, 4'b0100);
        dp = 4'b0000;

        // 6: disable during digit 1 drive with an update pending
        for (int i = 0; i < 9; i++) tick();
        load = 1'b1; value = 16'h5678;
        tick();
        load = 1'b0;
        chk("s6_busy_set", 32'(busy), 32'd1);
        tick(); tick();
        chk("s6_an_d1", 32'(an_n), 32'hD);
        chk("s6_seg_d1", 32'(seg_n), 32'(GC));
        enable = 1'b0;
        tick();
        chk("s6_off_an", 32'(an_n), 32'hF);
        chk("s6_off_seg", 32'(seg_n), 32'h7F);
        chk("s6_off_dp", 32'(dp_n), 32'd1);
        chk("s6_off_busy", 32'(busy), 32'd0);
        tick();
        chk("s6_off_ft", 32'(frame_tick), 32'd0);
        chk("s6_off_an2", 32'(an_n), 32'hF);
        enable = 1'b1;
        check_frame("s6_5678", {G5, G6, G7, G8}, 4'hF, 4'h0);

        // 6b: asynchronous reset mid-slot discards pending update
        for (int i = 0; i < 5; i++) tick();
        chk("s7_an_pre", 32'(an_n), 32'hE);
        chk("s7_seg_pre", 32'(seg_n), 32'(G8));
        load = 1'b1; value = 16'h9999;
        tick();
        load = 1'b0;
        chk("s7_busy_set", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("s7_rst_an", 32'(an_n), 32'hF);
        chk("s7_rst_seg", 32'(seg_n), 32'h7F);
        chk("s7_rst_dp", 32'(dp_n), 32'd1);
        chk("s7_rst_busy", 32'(busy), 32'd0);
        chk("s7_rst_ft", 32'(frame_tick), 32'd0);
        #1 rst_n = 1'b1;
        check_frame("s7_after_rst", {G0, G0, G0, G0}, 4'hF, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
